// File: rtl/pico_io_responder_pkg.sv
// Shared constants for the PicoBlaze-style port I/O responder.
//   PORT_*        : port_id values decoded by the responder
//   STAT_*        : bit positions inside the status byte read at PORT_FIFO_STAT
//   pack_status() : builds the status byte {full, empty, overflow, count[4:0]}
package pico_io_pkg;

  localparam logic [7:0] PORT_FIFO_DATA = 8'h20;
  localparam logic [7:0] PORT_FIFO_STAT = 8'h21;
  localparam logic [7:0] PORT_MEM_ADDR  = 8'h30;
  localparam logic [7:0] PORT_MEM_DATA  = 8'h31;

  localparam int STAT_FULL_BIT  = 7;
  localparam int STAT_EMPTY_BIT = 6;
  localparam int STAT_OVF_BIT   = 5;
  localparam int STAT_CNT_W     = 5;

  function automatic logic [7:0] pack_status(input logic full, input logic empty,
                                             input logic ovf,
                                             input logic [STAT_CNT_W-1:0] cnt);
    logic [7:0] s;
    s                 = {3'b000, cnt};
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_OVF_BIT]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/pico_io_responder_if.sv
// Port I/O bus between the soft-core initiator and the responder.
//   pb_port_id      : port address driven by the core
//   pb_out_port     : write data driven by the core
//   pb_write_strobe : single-cycle write enable
//   pb_read_strobe  : read indication (reads have no side effects)
//   pb_in_port      : registered read data returned to the core
interface pico_io_responder_if;
  logic [7:0] pb_port_id;
  logic [7:0] pb_out_port;
  logic       pb_write_strobe;
  logic       pb_read_strobe;
  logic [7:0] pb_in_port;

  modport master (output pb_port_id, output pb_out_port, output pb_write_strobe,
                  output pb_read_strobe, input pb_in_port);
  modport slave  (input pb_port_id, input pb_out_port, input pb_write_strobe,
                  input pb_read_strobe, output pb_in_port);
endinterface

// File: rtl/pico_io_responder_fifo.sv
// sync_fifo: 8-bit first-word-fall-through FIFO, depth 2**AW.
//   push/push_data : write request; accepted when not full or when popping
//   rd_ready       : consumer pop; takes effect only while rd_valid
//   rd_data        : head byte (undefined while empty)
//   rd_valid/empty/full/count : occupancy status
//   ovf_evt        : one-cycle pulse when a push is dropped
module sync_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          rd_ready,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf_evt
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          pop_ok, push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign rd_valid = !empty;
  assign count    = count_q;
  assign rd_data  = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a push into a full FIFO is legal then.
  assign pop_ok  = rd_ready && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign ovf_evt = push && full && !pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pico_io_responder.sv
// pico_io_responder: system-side responder for the PicoBlaze-style port bus.
//   clk, rst        : clock, asynchronous active-high reset
//   pb (slave)      : core port bus; 0x30 address latch, 0x31 Mem1 data,
//                     0x20 FIFO push, 0x21 FIFO status / overflow clear
//   ld_we/addr/data : Mem1 preload write port (wins over a same-address core write)
//   fifo_rd_*       : FWFT consumer side of the push FIFO
//   fifo_count      : FIFO occupancy
//   fifo_overflow   : sticky, set when a push was dropped
module pico_io_responder
  import pico_io_pkg::*;
#(
  parameter int MEM_AW  = 3,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  pico_io_responder_if.slave pb,
  input  logic               ld_we,
  input  logic [MEM_AW-1:0]  ld_addr,
  input  logic [7:0]         ld_data,
  output logic [7:0]         fifo_rd_data,
  output logic               fifo_rd_valid,
  input  logic               fifo_rd_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               fifo_overflow
);

  localparam int MEM_DEPTH = 1 << MEM_AW;

  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        in_port_q, in_port_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        mem_q [MEM_DEPTH];
  logic              core_mem_we, fifo_push, ovf_clr, ovf_evt;
  logic              fifo_full, fifo_empty;
  logic              unused_read_strobe;

  // Reads are side-effect free, so the read strobe carries no information here.
  assign unused_read_strobe = pb.pb_read_strobe;

  sync_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (pb.pb_out_port),
    .rd_ready  (fifo_rd_ready),
    .rd_data   (fifo_rd_data),
    .rd_valid  (fifo_rd_valid),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .ovf_evt   (ovf_evt)
  );

  always_comb begin
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    core_mem_we = 1'b0;
    fifo_push   = 1'b0;
    ovf_clr     = 1'b0;
    if (pb.pb_write_strobe) begin
      case (pb.pb_port_id)
        PORT_MEM_ADDR:  addr_d      = pb.pb_out_port[MEM_AW-1:0];
        // The preload port owns the cell when both target the same address.
        PORT_MEM_DATA:  core_mem_we = !(ld_we && (ld_addr == addr_q));
        PORT_FIFO_DATA: fifo_push   = 1'b1;
        PORT_FIFO_STAT: ovf_clr     = 1'b1;
        default: ;
      endcase
    end
    // Set is evaluated last so a drop in the clearing cycle is not lost.
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;

    case (pb.pb_port_id)
      PORT_MEM_DATA:  in_port_d = mem_q[addr_q];
      PORT_FIFO_STAT: in_port_d = pack_status(fifo_full, fifo_empty, ovf_q,
                                              STAT_CNT_W'(fifo_count));
      PORT_MEM_ADDR:  in_port_d = 8'(addr_q);
      default:        in_port_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      in_port_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      in_port_q <= in_port_d;
      ovf_q     <= ovf_d;
    end
  end

  // Mem1 contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we)       mem_q[ld_addr] <= ld_data;
    if (core_mem_we) mem_q[addr_q]  <= pb.pb_out_port;
  end

  assign pb.pb_in_port  = in_port_q;
  assign fifo_overflow  = ovf_q;

endmodule

// File: tb/tb_pico_io_responder.sv
module tb_pico_io_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_we = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_valid;
  logic       fifo_rd_ready = 1'b0;
  logic [4:0] fifo_count;
  logic       fifo_overflow;
  logic [7:0] cap;

  int n_cmp = 0;
  int n_bad = 0;

  pico_io_responder_if bus ();

  pico_io_responder #(.MEM_AW(3), .FIFO_AW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pb            (bus),
    .ld_we         (ld_we),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_valid (fifo_rd_valid),
    .fifo_rd_ready (fifo_rd_ready),
    .fifo_count    (fifo_count),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; one posedge performs the write, returns at the next negedge.
  task automatic pb_write(input logic [7:0] port, input logic [7:0] data);
    bus.pb_port_id      = port;
    bus.pb_out_port     = data;
    bus.pb_write_strobe = 1'b1;
    @(negedge clk);
    bus.pb_write_strobe = 1'b0;
  endtask

  task automatic pb_read(input logic [7:0] port, output logic [7:0] data);
    bus.pb_port_id = port;
    @(negedge clk);
    @(negedge clk);
    data = bus.pb_in_port;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.pb_port_id      = 8'h00;
    bus.pb_out_port     = 8'h00;
    bus.pb_write_strobe = 1'b0;
    bus.pb_read_strobe  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_port", bus.pb_in_port, 16'h00);
    chk("rst_count", fifo_count, 16'h0);
    chk("rst_valid", fifo_rd_valid, 16'h0);
    chk("rst_ovf", fifo_overflow, 16'h0);
    rst = 1'b0;

    // Preload Mem1 with A0..A7
    for (int i = 0; i < 8; i++) begin
      ld_we = 1'b1; ld_addr = 3'(i); ld_data = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    ld_we = 1'b0;

    // Initiator sequence: set address, two wait cycles, capture, push
    for (int i = 0; i < 8; i++) begin
      pb_write(8'h30, 8'(i));
      pb_read(8'h31, cap);
      chk($sformatf("init_read%0d", i), cap, 16'(8'hA0 + 8'(i)));
      pb_write(8'h20, cap);
    end
    chk("init_count", fifo_count, 16'd8);
    chk("init_ovf", fifo_overflow, 16'h0);

    // Latency: address write at E0 (port 0x30 mux shows old addr 7), data after E0+1
    pb_write(8'h30, 8'h05);
    chk("lat_before", bus.pb_in_port, 16'h07);
    bus.pb_port_id = 8'h31;
    @(negedge clk);
    chk("lat_after", bus.pb_in_port, 16'hA5);
    pb_write(8'h30, 8'h0B);
    bus.pb_port_id = 8'h31;
    @(negedge clk);
    chk("addr_wrap", bus.pb_in_port, 16'hA3);

    // Drain 8 bytes in order
    fifo_rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_valid%0d", i), fifo_rd_valid, 16'h1);
      chk($sformatf("drain_data%0d", i), fifo_rd_data, 16'(8'hA0 + 8'(i)));
      @(negedge clk);
    end
    fifo_rd_ready = 1'b0;
    chk("drain_empty", fifo_rd_valid, 16'h0);
    chk("drain_ovf", fifo_overflow, 16'h0);

    // Collision at addr 3: preload wins
    ld_we = 1'b1; ld_addr = 3'd3; ld_data = 8'h33;
    pb_write(8'h31, 8'h99);
    ld_we = 1'b0;
    pb_read(8'h31, cap);
    chk("coll_same", cap, 16'h33);
    // Different addresses: both land
    ld_we = 1'b1; ld_addr = 3'd4; ld_data = 8'h44;
    pb_write(8'h31, 8'h55);
    ld_we = 1'b0;
    pb_read(8'h31, cap);
    chk("coll_core", cap, 16'h55);
    pb_write(8'h30, 8'h04);
    pb_read(8'h31, cap);
    chk("coll_ld", cap, 16'h44);

    // 17 pushes into the FIFO with no consumer
    for (int i = 0; i <= 16; i++) pb_write(8'h20, 8'(i));
    chk("full_count", fifo_count, 16'd16);
    chk("full_ovf", fifo_overflow, 16'h1);
    chk("full_head", fifo_rd_data, 16'h00);
    pb_read(8'h21, cap);
    chk("stat_full", cap, 16'hB0);

    // Clear overflow; the mux at the clearing edge still sees it set
    pb_write(8'h21, 8'hFF);
    @(negedge clk);
    chk("stat_clr", bus.pb_in_port, 16'h90);
    chk("ovf_clr", fifo_overflow, 16'h0);

    // Full: push and pop together
    fifo_rd_ready = 1'b1;
    pb_write(8'h20, 8'h77);
    fifo_rd_ready = 1'b0;
    chk("pp_count", fifo_count, 16'd16);
    chk("pp_ovf", fifo_overflow, 16'h0);
    fifo_rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("pp_data%0d", i), fifo_rd_data, (i < 15) ? 16'(i + 1) : 16'h77);
      @(negedge clk);
    end
    fifo_rd_ready = 1'b0;
    chk("pp_empty", fifo_count, 16'd0);

    // Empty: push and ready together
    fifo_rd_ready = 1'b1;
    pb_write(8'h20, 8'h5A);
    fifo_rd_ready = 1'b0;
    chk("ep_count", fifo_count, 16'd1);
    chk("ep_valid", fifo_rd_valid, 16'h1);
    chk("ep_data", fifo_rd_data, 16'h5A);

    // Unmapped port reads zero
    pb_read(8'h55, cap);
    chk("unmapped", cap, 16'h00);

    // Reset mid-transfer after 3 pushes
    for (int i = 0; i < 3; i++) pb_write(8'h20, 8'hC0 + 8'(i));
    chk("pre_rst_count", fifo_count, 16'd4);
    bus.pb_port_id = 8'h30;
    @(negedge clk);
    chk("pre_rst_in", bus.pb_in_port, 16'h04);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", fifo_count, 16'd0);
    chk("mid_rst_valid", fifo_rd_valid, 16'h0);
    chk("mid_rst_in", bus.pb_in_port, 16'h00);
    @(negedge clk);
    rst = 1'b0;
    pb_read(8'h30, cap);
    chk("post_rst_addr", cap, 16'h00);
    pb_write(8'h30, 8'h02);
    pb_read(8'h31, cap);
    chk("post_rst_mem2", cap, 16'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
